// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the sized-access data memory controller
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response channel between load/store unit and dmem_ctrl
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store lane steering/byte enables and load extract/extend
// Optional DMEM_ROTATE_UNALIGNED_EN: word loads rotate right by the byte lane.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] word_val;

    assign byte_val = rword[{lane, 3'b000} +: 8];
    assign half_val = lane[1] ? rword[31:16] : rword[15:0];

`ifdef DMEM_ROTATE_UNALIGNED_EN
    logic [63:0] rot_dbl;
    // Shifting a doubled word right yields a rotate in the low half.
    assign rot_dbl  = {rword, rword} >> {lane, 3'b000};
    assign word_val = rot_dbl[31:0];
`else
    assign word_val = rword;
`endif

    always_comb begin
        st_data = wdata;
        st_be   = BE_NONE;
        ld_data = word_val;
        case (size_e'(size))
            SIZE_BYTE: begin
                st_data = {4{wdata[7:0]}};
                st_be   = BE_BYTE0 << lane;
                ld_data = {{24{sign_ext & byte_val[7]}}, byte_val};
            end
            SIZE_HALF: begin
                st_data = {2{wdata[15:0]}};
                st_be   = lane[1] ? BE_HALF_HI : BE_HALF_LO;
                ld_data = {{16{sign_ext & half_val[15]}}, half_val};
            end
            SIZE_WORD: begin
                st_data = wdata;
                st_be   = BE_WORD;
                ld_data = word_val;
            end
            default: begin
                st_be   = BE_NONE;
                ld_data = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - single-port sized-access data memory with wait states and faults
// Optional DMEM_ROTATE_UNALIGNED_EN: unaligned word accesses do not fault.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH       = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [32:0] SPAN    = 33'(DEPTH) << 2;
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [31:0]   ram [DEPTH];
    logic [31:0]   off;
    logic [AW-1:0] widx;
    logic [31:0]   rword;
    logic          accept;
    logic          fault;
    logic [31:0]   st_data;
    logic [3:0]    st_be;
    logic [31:0]   ld_data;
    logic [31:0]   res_data;

    state_e        state;
    logic [3:0]    wcnt;
    logic [31:0]   pend_data;
    logic          pend_fault;

    // Subtracting the base lets one unsigned compare catch both range ends.
    assign off    = bus.req_addr - BASE_ADDR;
    assign widx   = off[AW+1:2];
    assign rword  = ram[widx];
    assign accept = bus.req_valid & bus.req_ready;

    always_comb begin
        fault = ({1'b0, off} >= SPAN);
        case (size_e'(bus.req_size))
            SIZE_HALF: if (bus.req_addr[0]) fault = 1'b1;
            SIZE_WORD: begin
`ifndef DMEM_ROTATE_UNALIGNED_EN
                if (bus.req_addr[1:0] != 2'b00) fault = 1'b1;
`endif
            end
            SIZE_RSVD: fault = 1'b1;
            default: ;
        endcase
    end

    dmem_lane_align u_align (
        .size     (bus.req_size),
        .lane     (bus.req_addr[1:0]),
        .sign_ext (bus.req_signed),
        .wdata    (bus.req_wdata),
        .rword    (rword),
        .st_data  (st_data),
        .st_be    (st_be),
        .ld_data  (ld_data)
    );

    assign res_data = (fault | bus.req_write) ? 32'h0 : ld_data;

    // Store commits on the accept edge so the next request already sees it.
    always_ff @(posedge clk) begin
        if (rst_n && accept && bus.req_write && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) ram[widx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            wcnt          <= 4'd0;
            pend_data     <= 32'h0;
            pend_fault    <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_fault <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bus.req_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state         <= ST_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_rdata <= res_data;
                            bus.rsp_fault <= fault;
                        end else begin
                            state      <= ST_WAIT;
                            wcnt       <= WS_LOAD;
                            pend_data  <= res_data;
                            pend_fault <= fault;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wcnt == 4'd0) begin
                        state         <= ST_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= pend_data;
                        bus.rsp_fault <= pend_fault;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state         <= ST_IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard bench for dmem_ctrl at zero and three wait states
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic        valid_a, valid_b;
    logic        t_write, t_signed;
    logic [1:0]  t_size;
    logic [31:0] t_addr, t_wdata;

    dmem_if bus_a ();
    dmem_if bus_b ();

    assign bus_a.req_valid  = valid_a;
    assign bus_a.req_write  = t_write;
    assign bus_a.req_size   = t_size;
    assign bus_a.req_signed = t_signed;
    assign bus_a.req_addr   = t_addr;
    assign bus_a.req_wdata  = t_wdata;
    assign bus_b.req_valid  = valid_b;
    assign bus_b.req_write  = t_write;
    assign bus_b.req_size   = t_size;
    assign bus_b.req_signed = t_signed;
    assign bus_b.req_addr   = t_addr;
    assign bus_b.req_wdata  = t_wdata;

    dmem_ctrl #(.DEPTH(4096), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut_a (
        .clk(clk), .rst_n(rst_a), .bus(bus_a)
    );
    dmem_ctrl #(.DEPTH(4096), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut_b (
        .clk(clk), .rst_n(rst_b), .bus(bus_b)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        fault;
        int          acc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_rsp(input string dut, input exp_t e, input logic [31:0] rdata,
                             input logic fault, input int lat);
        chk($sformatf("%s_rdata#%0d", dut, e.id), rdata, e.data);
        chk($sformatf("%s_fault#%0d", dut, e.id), 32'(fault), 32'(e.fault));
        chk($sformatf("%s_latency#%0d", dut, e.id), 32'(cyc - e.acc), 32'(lat));
    endtask

    always @(negedge clk) begin
        if (bus_a.rsp_valid) begin
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_rsp got rdata %h expected no response", bus_a.rsp_rdata);
            end else begin
                check_rsp("a", q_a.pop_front(), bus_a.rsp_rdata, bus_a.rsp_fault, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.rsp_valid) begin
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_rsp got rdata %h expected no response", bus_b.rsp_rdata);
            end else begin
                check_rsp("b", q_b.pop_front(), bus_b.rsp_rdata, bus_b.rsp_fault, 4);
            end
        end
    end

    // Issue one request to DUT a (sel=0) or b (sel=1); push its expectation unless no_exp.
    task automatic issue(input bit sel, input int id, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_f, input bit no_exp);
        int n;
        @(negedge clk);
        t_write = w; t_size = sz; t_signed = sg; t_addr = addr; t_wdata = wd;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        n = 0;
        while (!(sel ? bus_b.req_ready : bus_a.req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout#%0d got ready 0 expected 1 within 50 cycles", id);
            valid_a = 1'b0; valid_b = 1'b0;
            return;
        end
        if (!no_exp) begin
            if (sel) q_b.push_back('{id, exp_d, exp_f, cyc});
            else     q_a.push_back('{id, exp_d, exp_f, cyc});
        end
        @(negedge clk);
        valid_a = 1'b0; valid_b = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(q_a.size() + q_b.size()), 32'd0);
    endtask

    initial begin
        valid_a = 0; valid_b = 0; t_write = 0; t_size = 0; t_signed = 0;
        t_addr = 0; t_wdata = 0;
        rst_a = 0; rst_b = 0;
        repeat (3) @(negedge clk);
        chk("reset_ready_a", 32'(bus_a.req_ready), 32'd1);
        chk("reset_valid_a", 32'(bus_a.rsp_valid), 32'd0);
        chk("reset_rdata_a", bus_a.rsp_rdata, 32'h0);
        chk("reset_fault_a", 32'(bus_a.rsp_fault), 32'd0);
        chk("reset_ready_b", 32'(bus_b.req_ready), 32'd1);
        chk("reset_valid_b", 32'(bus_b.rsp_valid), 32'd0);
        rst_a = 1; rst_b = 1;

        // sel id w sz sg addr wdata exp_data exp_fault no_exp
        issue(0, 1, 1, SIZE_WORD, 0, 32'h1000, 32'hDEADBEEF, 32'h0, 0, 0);
        issue(0, 2, 0, SIZE_WORD, 0, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0);
        issue(1, 3, 1, SIZE_WORD, 0, 32'h1000, 32'hDEADBEEF, 32'h0, 0, 0);
        issue(1, 4, 0, SIZE_WORD, 0, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0);

        issue(0, 5, 1, SIZE_BYTE, 0, 32'h1001, 32'h000000AA, 32'h0, 0, 0);
        issue(0, 6, 1, SIZE_BYTE, 0, 32'h1003, 32'h00000055, 32'h0, 0, 0);
        issue(0, 7, 0, SIZE_WORD, 0, 32'h1000, 32'h0, 32'h55ADAAEF, 0, 0);
        issue(0, 8, 0, SIZE_BYTE, 1, 32'h1001, 32'h0, 32'hFFFFFFAA, 0, 0);
        issue(0, 9, 0, SIZE_BYTE, 0, 32'h1001, 32'h0, 32'h000000AA, 0, 0);
        drain();
        repeat (3) @(negedge clk);
        chk("rdata_hold_a", bus_a.rsp_rdata, 32'h000000AA);
        chk("valid_idle_a", 32'(bus_a.rsp_valid), 32'd0);

        issue(0, 10, 0, SIZE_HALF, 1, 32'h1000, 32'h0, 32'hFFFFAAEF, 0, 0);
        issue(0, 11, 0, SIZE_HALF, 1, 32'h1002, 32'h0, 32'h000055AD, 0, 0);

        issue(0, 12, 1, SIZE_HALF, 0, 32'h1001, 32'h0000FFFF, 32'h0, 1, 0);
        issue(0, 13, 0, SIZE_WORD, 0, 32'h1000, 32'h0, 32'h55ADAAEF, 0, 0);
        issue(0, 14, 0, SIZE_WORD, 0, 32'h4000, 32'h0, 32'h0, 1, 0);
        issue(0, 15, 0, SIZE_RSVD, 0, 32'h1000, 32'h0, 32'h0, 1, 0);
        issue(0, 16, 0, SIZE_BYTE, 0, 32'h3FFF, 32'h0, 32'h0, 0, 0);
`ifdef DMEM_ROTATE_UNALIGNED_EN
        issue(0, 17, 0, SIZE_WORD, 0, 32'h1001, 32'h0, 32'hEF55ADAA, 0, 0);
`else
        issue(0, 17, 0, SIZE_WORD, 0, 32'h1001, 32'h0, 32'h0, 1, 0);
`endif
        drain();

        // Store accepted into WAIT, then reset drops its response but keeps the write.
        issue(1, 18, 1, SIZE_WORD, 0, 32'h2000, 32'h12345678, 32'h0, 0, 1);
        chk("b_in_wait_ready", 32'(bus_b.req_ready), 32'd0);
        chk("b_in_wait_valid", 32'(bus_b.rsp_valid), 32'd0);
        rst_b = 0;
        #1;
        chk("b_async_reset_ready", 32'(bus_b.req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_b = 1;
        repeat (6) @(negedge clk);
        chk("b_after_reset_ready", 32'(bus_b.req_ready), 32'd1);
        chk("b_after_reset_valid", 32'(bus_b.rsp_valid), 32'd0);
        issue(1, 19, 0, SIZE_WORD, 0, 32'h2000, 32'h0, 32'h12345678, 0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
